count_extender: RTL and testbench
=================================

COUNT_EXTENDER -- requirements
Module: count_extender

Interface
REQ-001 Parameter EXT_W, default 8: width of the wrap-extension (upper) field.
REQ-002 Parameter CNT_W, default 4: width of the monitored count; fixed at 4 for this release.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 load  input  1  the same load strobe that drives the upstream 4-bit loadable up/down counter.
REQ-006 mode  input  1  the same direction control that drives that counter; 1 = up, 0 = down.
REQ-007 cnt_in  input  CNT_W  count output of that counter.
REQ-008 clr_err  input  1  clears a sticky step error; 1-cycle pulse.
REQ-009 ext_cnt  output  EXT_W+CNT_W  registered extended count, {ext_hi, last accepted cnt_in}.
REQ-010 wrap_up  output  1  1-cycle pulse on an accepted 15->0 up step.
REQ-011 wrap_dn  output  1  1-cycle pulse on an accepted 0->15 down step.
REQ-012 step_err  output  1  sticky flag for an illegal count step.

Function
REQ-013 Internal state: FSM {IDLE, TRACK, ERROR}; prev_cnt (CNT_W), mode_q (1), ext_hi (EXT_W).
REQ-014 All evaluation occurs at the rising edge; every output is registered, and results appear in the cycle after the sampling edge.
REQ-015 IDLE with load=0: capture cnt_in into prev_cnt and mode into mode_q; go to TRACK; no pulse.
REQ-016 IDLE with load=1: stay in IDLE and clear ext_hi to 0.
REQ-017 TRACK with load=1: go to IDLE, clear ext_hi, suppress pulses; the post-load value becomes the next baseline.
REQ-018 TRACK with load=0: the legal step is prev_cnt+1 mod 16 if mode_q=1, else prev_cnt-1 mod 16; mode_q is the direction sampled on the previous edge, not the current mode.
REQ-019 Legal step: update prev_cnt to cnt_in and mode_q to mode.
REQ-020 Legal up step 15->0: ext_hi increments and wrap_up=1 for one cycle.
REQ-021 Legal down step 0->15: ext_hi decrements and wrap_dn=1 for one cycle.
REQ-022 ext_hi arithmetic is modulo 2^EXT_W: 0xFF+1 gives 0x00, and 0x00-1 gives 0xFF.
REQ-023 Illegal step (any other value, including a repeat of prev_cnt): go to ERROR and set step_err=1; freeze ext_cnt; no pulse.
REQ-024 ERROR: hold all state; load is ignored; wrap_up and wrap_dn stay 0.
REQ-025 clr_err=1 in any state: step_err is cleared; the FSM goes to IDLE; ext_hi is held unless load=1 in the same cycle, in which case ext_hi is cleared.
REQ-026 Priority: rst > clr_err > load > step evaluation.
REQ-027 wrap_up and wrap_dn are never both 1 in the same cycle.

Reset
REQ-028 With rst=1 at an edge: FSM=IDLE; prev_cnt=0; mode_q=0; ext_hi=0; ext_cnt=0; wrap_up=0; wrap_dn=0; step_err=0.
REQ-029 Reset asserted mid-operation, including in ERROR, discards all history; tracking restarts from IDLE on the first edge with rst=0.

Configuration
REQ-030 Macro STEP_CHECK_EN, when defined: step checking and the ERROR state exist exactly as in REQ-023 to REQ-025.
REQ-031 STEP_CHECK_EN undefined: step_err is tied to 0, ERROR is absent, and clr_err is ignored.
REQ-032 STEP_CHECK_EN undefined, illegal step: silently rebaseline (prev_cnt=cnt_in, mode_q=mode), with no pulse and no ext_hi change.

Verification
REQ-033 Reset: rst=1 for 2 edges -> ext_cnt=0x000, wrap_up=0, wrap_dn=0, step_err=0.
REQ-034 Up wrap: load with cnt_in=6, then mode=1 with cnt_in 6..15,0,1 -> one wrap_up pulse after the edge sampling 0; ext_cnt 0x00F -> 0x010 -> 0x011.
REQ-035 Down wrap: from load at 2, mode=0 with cnt_in 2,1,0,15 -> one wrap_dn pulse; ext_cnt=0xFFF; ext_hi=0xFF.
REQ-036 Extension wrap: ext_hi=0xFF, then an up step 15->0 -> ext_cnt=0x000 with wrap_up=1.
REQ-037 Step error (macro defined): prev_cnt=5, mode_q=1, cnt_in=9 -> step_err=1 and ext_cnt frozen at 0x005; load ignored; clr_err pulse -> step_err=0, FSM IDLE.
REQ-038 Macro undefined, same stimulus as REQ-037 -> step_err stays 0; ext_cnt=0x009; no pulses.

Source files
------------

// File: rtl/count_extender.sv
// Extends a 4-bit up/down counter with an EXT_W-bit wrap count by watching its steps.
// Optional step checking with sticky error and ERROR state: define STEP_CHECK_EN.
module count_extender #(
    parameter int EXT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   mode,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   clr_err,
    output logic [EXT_W+CNT_W-1:0] ext_cnt,
    output logic                   wrap_up,
    output logic                   wrap_dn,
    output logic                   step_err
);

`ifdef STEP_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] prev_cnt;
    logic             mode_q;
    logic [EXT_W-1:0] ext_hi;
    logic [CNT_W-1:0] step_exp;
    logic             step_ok;

    // The expected step uses the direction sampled on the previous edge.
    assign step_exp = mode_q ? prev_cnt + CNT_W'(1) : prev_cnt - CNT_W'(1);
    assign step_ok  = (cnt_in == step_exp);
    assign ext_cnt  = {ext_hi, prev_cnt};

`ifndef STEP_CHECK_EN
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign step_err       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            prev_cnt <= '0;
            mode_q   <= 1'b0;
            ext_hi   <= '0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
`ifdef STEP_CHECK_EN
            step_err <= 1'b0;
`endif
        end else begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
`ifdef STEP_CHECK_EN
            if (clr_err) begin
                step_err <= 1'b0;
                state    <= IDLE;
                if (load) begin
                    ext_hi <= '0;
                end
            end else begin
`endif
            case (state)
                IDLE: begin
                    if (load) begin
                        ext_hi <= '0;
                    end else begin
                        prev_cnt <= cnt_in;
                        mode_q   <= mode;
                        state    <= TRACK;
                    end
                end
                TRACK: begin
                    if (load) begin
                        ext_hi <= '0;
                        state  <= IDLE;
                    end else if (step_ok) begin
                        prev_cnt <= cnt_in;
                        mode_q   <= mode;
                        if (mode_q && (prev_cnt == '1)) begin
                            ext_hi  <= ext_hi + EXT_W'(1);
                            wrap_up <= 1'b1;
                        end else if (!mode_q && (prev_cnt == '0)) begin
                            ext_hi  <= ext_hi - EXT_W'(1);
                            wrap_dn <= 1'b1;
                        end
                    end else begin
`ifdef STEP_CHECK_EN
                        step_err <= 1'b1;
                        state    <= ERROR;
`else
                        prev_cnt <= cnt_in;
                        mode_q   <= mode;
`endif
                    end
                end
`ifdef STEP_CHECK_EN
                ERROR: begin
                    state <= ERROR;
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef STEP_CHECK_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_count_extender.sv
// Directed self-checking bench for count_extender; covers both STEP_CHECK_EN builds.
module tb_count_extender;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  cnt_in = '0;
    logic        clr_err = 1'b0;
    logic [11:0] ext_cnt;
    logic        wrap_up;
    logic        wrap_dn;
    logic        step_err;

    int tests = 0;
    int fails = 0;

    count_extender #(.EXT_W(8), .CNT_W(4)) dut (
        .clock   (clock),
        .rst     (rst),
        .load    (load),
        .mode    (mode),
        .cnt_in  (cnt_in),
        .clr_err (clr_err),
        .ext_cnt (ext_cnt),
        .wrap_up (wrap_up),
        .wrap_dn (wrap_dn),
        .step_err(step_err)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic r, input logic l, input logic m,
                         input logic [3:0] c, input logic ce);
        @(negedge clock);
        rst = r; load = l; mode = m; cnt_in = c; clr_err = ce;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        tests++; if (ext_cnt !== 12'h000) begin fails++; $display("FAIL reset_ext_cnt got %h exp 000", ext_cnt); end
        tests++; if (wrap_up !== 1'b0) begin fails++; $display("FAIL reset_wrap_up got %b exp 0", wrap_up); end
        tests++; if (wrap_dn !== 1'b0) begin fails++; $display("FAIL reset_wrap_dn got %b exp 0", wrap_dn); end
        tests++; if (step_err !== 1'b0) begin fails++; $display("FAIL reset_step_err got %b exp 0", step_err); end
    endtask

    task automatic test_up_wrap;
        drive(1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
        tests++; if (ext_cnt[11:4] !== 8'h00) begin fails++; $display("FAIL up_load_hi got %h exp 00", ext_cnt[11:4]); end
        for (int unsigned i = 6; i <= 15; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
            tests++;
            if (ext_cnt !== 12'(i) || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
                fails++; $display("FAIL up_step%0d got %h/%b%b exp %h/00", i, ext_cnt, wrap_up, wrap_dn, 12'(i));
            end
        end
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tests++; if (ext_cnt !== 12'h010) begin fails++; $display("FAIL up_wrap_cnt got %h exp 010", ext_cnt); end
        tests++; if (wrap_up !== 1'b1 || wrap_dn !== 1'b0) begin fails++; $display("FAIL up_wrap_pulse got %b%b exp 10", wrap_up, wrap_dn); end
        drive(1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        tests++; if (ext_cnt !== 12'h011) begin fails++; $display("FAIL up_after_cnt got %h exp 011", ext_cnt); end
        tests++; if (wrap_up !== 1'b0) begin fails++; $display("FAIL up_after_pulse got %b exp 0", wrap_up); end
    endtask

    task automatic test_down_wrap;
        logic [3:0]  seq [3]   = '{4'd2, 4'd1, 4'd0};
        logic [11:0] exp_c [3] = '{12'h002, 12'h001, 12'h000};
        drive(1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        tests++; if (ext_cnt[11:4] !== 8'h00) begin fails++; $display("FAIL dn_load_hi got %h exp 00", ext_cnt[11:4]); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, seq[i], 1'b0);
            tests++;
            if (ext_cnt !== exp_c[i] || wrap_dn !== 1'b0) begin
                fails++; $display("FAIL dn_step%0d got %h/%b exp %h/0", i, ext_cnt, wrap_dn, exp_c[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd15, 1'b0);
        tests++; if (ext_cnt !== 12'hFFF) begin fails++; $display("FAIL dn_wrap_cnt got %h exp fff", ext_cnt); end
        tests++; if (wrap_dn !== 1'b1 || wrap_up !== 1'b0) begin fails++; $display("FAIL dn_wrap_pulse got %b%b exp 01", wrap_up, wrap_dn); end
        drive(1'b0, 1'b0, 1'b0, 4'd14, 1'b0);
        tests++; if (ext_cnt !== 12'hFFE || wrap_dn !== 1'b0) begin fails++; $display("FAIL dn_after got %h/%b exp ffe/0", ext_cnt, wrap_dn); end
    endtask

    // Direction change: the 14->13 step is still checked as down (previous mode).
    task automatic test_ext_wrap;
        drive(1'b0, 1'b0, 1'b1, 4'd13, 1'b0);
        tests++; if (ext_cnt !== 12'hFFD) begin fails++; $display("FAIL ext_turn got %h exp ffd", ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd14, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        tests++; if (ext_cnt !== 12'hFFF) begin fails++; $display("FAIL ext_pre got %h exp fff", ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tests++; if (ext_cnt !== 12'h000 || wrap_up !== 1'b1) begin fails++; $display("FAIL ext_wrap got %h/%b exp 000/1", ext_cnt, wrap_up); end
    endtask

    task automatic test_step;
        drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int unsigned i = 1; i <= 5; i++) drive(1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
        tests++; if (ext_cnt !== 12'h015) begin fails++; $display("FAIL step_base got %h exp 015", ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
`ifdef STEP_CHECK_EN
        tests++; if (step_err !== 1'b1 || ext_cnt !== 12'h015) begin fails++; $display("FAIL step_err_set got %b/%h exp 1/015", step_err, ext_cnt); end
        drive(1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        tests++; if (step_err !== 1'b1 || ext_cnt !== 12'h015) begin fails++; $display("FAIL step_load_ign got %b/%h exp 1/015", step_err, ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd10, 1'b0);
        tests++; if (ext_cnt !== 12'h015 || wrap_up !== 1'b0) begin fails++; $display("FAIL step_hold got %h/%b exp 015/0", ext_cnt, wrap_up); end
        drive(1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
        tests++; if (step_err !== 1'b0 || ext_cnt !== 12'h015) begin fails++; $display("FAIL step_clr got %b/%h exp 0/015", step_err, ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
        tests++; if (ext_cnt !== 12'h017) begin fails++; $display("FAIL step_idle_cap got %h exp 017", ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
        tests++; if (step_err !== 1'b1 || ext_cnt !== 12'h017) begin fails++; $display("FAIL step_repeat got %b/%h exp 1/017", step_err, ext_cnt); end
        drive(1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
        tests++; if (step_err !== 1'b0 || ext_cnt[11:4] !== 8'h00) begin fails++; $display("FAIL step_clr_load got %b/%h exp 0/00", step_err, ext_cnt[11:4]); end
`else
        tests++; if (step_err !== 1'b0 || ext_cnt !== 12'h019) begin fails++; $display("FAIL step_rebase got %b/%h exp 0/019", step_err, ext_cnt); end
        tests++; if (wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin fails++; $display("FAIL step_nopulse got %b%b exp 00", wrap_up, wrap_dn); end
        drive(1'b0, 1'b0, 1'b1, 4'd10, 1'b0);
        tests++; if (ext_cnt !== 12'h01A) begin fails++; $display("FAIL step_after got %h exp 01a", ext_cnt); end
        drive(1'b0, 1'b0, 1'b1, 4'd11, 1'b1);
        tests++; if (ext_cnt !== 12'h01B || step_err !== 1'b0) begin fails++; $display("FAIL step_clr_ign got %h/%b exp 01b/0", ext_cnt, step_err); end
`endif
    endtask

    task automatic test_mid_reset;
        drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        tests++; if (ext_cnt !== 12'h000 || step_err !== 1'b0 || wrap_up !== 1'b0) begin
            fails++; $display("FAIL midrst got %h/%b/%b exp 000/0/0", ext_cnt, step_err, wrap_up);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        tests++; if (ext_cnt !== 12'h003) begin fails++; $display("FAIL midrst_restart got %h exp 003", ext_cnt); end
        drive(1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tests++; if (ext_cnt !== 12'h002 || step_err !== 1'b0) begin fails++; $display("FAIL midrst_track got %h/%b exp 002/0", ext_cnt, step_err); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_ext_wrap();
        test_step();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
